sim_mem_arbiter: RTL and testbench
==================================

Name: sim_mem_arbiter

Overview:
- Shares one simulated physical-memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Arbitrates between them, serialises accesses, and injects a configurable access latency.
- Drives a single downstream port, which is backed by the DPI pmem read/write functions in the memory model.
- Sits between IFU/LSU and the simulated memory model in the NPC core.

Parameters:
- XLEN, 32, address/data width.
- LATENCY, 2, wait cycles inserted before the memory access (legal 0..15).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  XLEN  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU accepts response
- ifu_resp_data  out  32  instruction word
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  XLEN  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  XLEN  write data
- lsu_req_wmask  in  4  byte-enable mask
- lsu_resp_valid  out  1  LSU response valid (reads and writes)
- lsu_resp_ready  in  1  LSU accepts response
- lsu_resp_data  out  XLEN  read data (0 for writes)
- mem_valid  out  1  one-cycle access strobe to the memory model
- mem_addr  out  XLEN  word-aligned address (bits [1:0] forced to 0)
- mem_wen  out  1  write enable
- mem_wdata  out  XLEN  write data
- mem_wmask  out  4  byte mask
- mem_rdata  in  XLEN  read data, combinationally valid in the mem_valid cycle

Behaviour:
- Clock is `clock`; reset is `reset`, synchronous and active-high.
- State machine states: IDLE, WAIT, ACCESS, RESP.
- Reset values:
  - State = IDLE; latency counter = 0; owner = NONE.
  - All outputs 0: both req_ready, both resp_valid, mem_valid, resp data.
- IDLE:
  - The grant selects at most one requester whose valid is high.
  - Only the granted requester sees req_ready = 1, combinationally in the same cycle.
  - Handshake is valid && ready. On handshake:
    - Latch owner, addr, wen, wdata and wmask; IFU requests latch wen = 0 and wmask = 4'hF.
    - Load counter = LATENCY.
    - Next state = WAIT if LATENCY > 0, otherwise ACCESS.
- WAIT:
  - Counter decrements each cycle.
  - Leave for ACCESS in the cycle the counter reaches 1.
  - Both req_ready = 0.
- ACCESS:
  - mem_valid = 1 for exactly one cycle, driven from the latched fields.
  - Capture mem_rdata into the response register; captured value is 0 when wen = 1.
  - Next state = RESP.
- RESP:
  - Owner's resp_valid = 1; data is held stable until resp_ready.
  - The handshake cycle returns the FSM to IDLE.
  - No new request is accepted in the handshake cycle itself, so there is one idle cycle between transactions.
- Latency: accept at cycle T gives resp_valid at T+LATENCY+2.
- Backpressure: resp_valid and data are held indefinitely while resp_ready = 0; mem_valid does not repeat.
- Requester valid may drop before it is granted; no request is latched in that case.
- Non-owner resp_valid is always 0.
- Simultaneous valid, fixed priority: LSU wins; the IFU stalls with ready = 0.
- Reset mid-operation: the pending transaction is discarded. No mem_valid is issued after reset, even if the FSM was in WAIT.
- Counter width: 4 bits.

Optional Feature:
- Macro: SIM_MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-grant register (reset = IFU, so LSU wins the first conflict) gives priority to the requester not served last.
  - The register updates only on a request handshake.
- Undefined: fixed LSU-over-IFU priority; no last-grant register.

Decomposition:
- Package sim_mem_arb_pkg:
  - State enum {IDLE, WAIT, ACCESS, RESP}.
  - Owner enum {NONE, IFU, LSU}.
  - Constant FULL_WMASK = 4'hF.
- Sub-module sim_mem_arb_select: combinational grant logic.
  - Inputs: both valids, idle flag, last grant.
  - Outputs: one-hot grant.
  - Contains the SIM_MEM_ARB_RR_EN variation.

Test Plan:
- IFU-only read, LATENCY = 2, addr 0x80000000, memory holds 0x00000413:
  - ready at T; mem_valid at T+3 with mem_addr 0x80000000.
  - ifu_resp_valid at T+4 with data 0x00000413.
- LSU write, addr 0x80001003, wdata 0xDEADBEEF, wmask 4'b0011:
  - mem_addr 0x80001000, mem_wen = 1, mem_wmask 0011.
  - lsu_resp_valid with data 0.
- Both valid in the same cycle:
  - Fixed priority: LSU granted twice in a row when LSU keeps requesting.
  - SIM_MEM_ARB_RR_EN: grants alternate LSU, IFU, LSU.
- ifu_resp_ready held 0 for 5 cycles in RESP:
  - resp_valid and data stable.
  - mem_valid asserted exactly once in total.
  - No LSU grant until the IFU handshake completes.
- reset pulsed in WAIT:
  - All outputs 0 the next cycle; no mem_valid issued.
  - A new IFU request accepted right after reset deasserts.
- LATENCY = 0:
  - Accept at T, mem_valid at T+1, resp_valid at T+2.

Source files
------------

// File: rtl/sim_mem_arb_pkg.sv
// Shared types and constants for the simulated-memory arbiter.
// Optional round-robin arbitration is enabled by defining SIM_MEM_ARB_RR_EN.
package sim_mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIfu,
    OwnLsu
  } owner_e;

  localparam logic [3:0]  FULL_WMASK = 4'hF;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned GNT_IFU    = 0;
  localparam int unsigned GNT_LSU    = 1;

endpackage

// File: rtl/sim_mem_arb_select.sv
// Combinational grant selection between IFU and LSU; one-hot {lsu, ifu}.
// SIM_MEM_ARB_RR_EN selects round-robin on conflicts, otherwise LSU has fixed priority.
module sim_mem_arb_select
  import sim_mem_arb_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  logic       idle_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_o
);

`ifndef SIM_MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;
`endif

  always_comb begin
    grant_o = 2'b00;
    if (idle_i) begin
`ifdef SIM_MEM_ARB_RR_EN
      if (ifu_valid_i && lsu_valid_i) begin
        // Conflict: favour whoever was not served last.
        if (last_grant_i == OwnLsu) grant_o[GNT_IFU] = 1'b1;
        else                        grant_o[GNT_LSU] = 1'b1;
      end else if (lsu_valid_i) begin
        grant_o[GNT_LSU] = 1'b1;
      end else if (ifu_valid_i) begin
        grant_o[GNT_IFU] = 1'b1;
      end
`else
      if (lsu_valid_i)      grant_o[GNT_LSU] = 1'b1;
      else if (ifu_valid_i) grant_o[GNT_IFU] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/sim_mem_arbiter.sv
// Serialises IFU and LSU accesses onto one simulated-memory port with injected latency.
// Define SIM_MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module sim_mem_arbiter
  import sim_mem_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [XLEN-1:0] ifu_req_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [31:0]     ifu_resp_data,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [XLEN-1:0] lsu_req_addr,
  input  logic            lsu_req_wen,
  input  logic [XLEN-1:0] lsu_req_wdata,
  input  logic [3:0]      lsu_req_wmask,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [XLEN-1:0] lsu_resp_data,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic [XLEN-1:0] mem_rdata
);

  state_e           state_q;
  owner_e           owner_q;
  owner_e           last_grant;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  resp_data_q;
  logic [3:0]       wmask_q;
  logic             wen_q;
  logic             mem_valid_q;
  logic             ifu_resp_valid_q;
  logic             lsu_resp_valid_q;
  logic             idle;
  logic [1:0]       grant;
  logic             ifu_hs;
  logic             lsu_hs;
  logic             resp_hs;

  // Gated by reset so no requester sees ready while reset is held.
  assign idle = (state_q == StIdle) && !reset;

  sim_mem_arb_select u_select (
    .ifu_valid_i  (ifu_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .idle_i       (idle),
    .last_grant_i (last_grant),
    .grant_o      (grant)
  );

  assign ifu_req_ready = grant[GNT_IFU];
  assign lsu_req_ready = grant[GNT_LSU];
  assign ifu_hs        = ifu_req_valid && ifu_req_ready;
  assign lsu_hs        = lsu_req_valid && lsu_req_ready;
  assign resp_hs       = (ifu_resp_valid_q && ifu_resp_ready) ||
                         (lsu_resp_valid_q && lsu_resp_ready);

`ifdef SIM_MEM_ARB_RR_EN
  owner_e last_grant_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= OwnIfu;
    end else if (lsu_hs) begin
      last_grant_q <= OwnLsu;
    end else if (ifu_hs) begin
      last_grant_q <= OwnIfu;
    end
  end
  assign last_grant = last_grant_q;
`else
  assign last_grant = OwnIfu;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      owner_q          <= OwnNone;
      cnt_q            <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      wen_q            <= 1'b0;
      resp_data_q      <= '0;
      mem_valid_q      <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (lsu_hs) begin
            owner_q <= OwnLsu;
            addr_q  <= lsu_req_addr;
            wen_q   <= lsu_req_wen;
            wdata_q <= lsu_req_wdata;
            wmask_q <= lsu_req_wmask;
          end else if (ifu_hs) begin
            owner_q <= OwnIfu;
            addr_q  <= ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= FULL_WMASK;
          end
          if (lsu_hs || ifu_hs) begin
            cnt_q <= CNT_W'(LATENCY);
            if (LATENCY > 0) begin
              state_q <= StWait;
            end else begin
              state_q     <= StAccess;
              mem_valid_q <= 1'b1;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= 1) begin
            state_q     <= StAccess;
            mem_valid_q <= 1'b1;
          end
        end
        StAccess: begin
          mem_valid_q      <= 1'b0;
          resp_data_q      <= wen_q ? '0 : mem_rdata;
          ifu_resp_valid_q <= (owner_q == OwnIfu);
          lsu_resp_valid_q <= (owner_q == OwnLsu);
          state_q          <= StResp;
        end
        StResp: begin
          if (resp_hs) begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            resp_data_q      <= '0;
            owner_q          <= OwnNone;
            state_q          <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_addr       = addr_q & ~XLEN'(3);
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_valid_q ? resp_data_q[31:0] : 32'h0;
  assign lsu_resp_data  = lsu_resp_valid_q ? resp_data_q : '0;

endmodule

// File: tb/tb_sim_mem_arbiter.sv
// Directed bench for sim_mem_arbiter: LATENCY=2 main instance plus a LATENCY=0 instance.
// Grant expectations follow SIM_MEM_ARB_RR_EN when it is defined.
module tb_sim_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_req_wen, lsu_resp_ready;
  logic [31:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;

  logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
  logic        mem_valid, mem_wen;
  logic [31:0] ifu_resp_data, lsu_resp_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        z_ifu_req_ready, z_ifu_resp_valid, z_lsu_req_ready, z_lsu_resp_valid;
  logic        z_mem_valid, z_mem_wen;
  logic [31:0] z_ifu_resp_data, z_lsu_resp_data, z_mem_addr, z_mem_wdata, z_mem_rdata;
  logic [3:0]  z_mem_wmask;

  int n_cmp = 0;
  int n_err = 0;
  int mem_cnt = 0;
  int m0;

`ifdef SIM_MEM_ARB_RR_EN
  localparam logic [2:0] ExpLsuGrant = 3'b101;
`else
  localparam logic [2:0] ExpLsuGrant = 3'b111;
`endif

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_A5A5);
  endfunction

  assign mem_rdata   = mem_model(mem_addr);
  assign z_mem_rdata = mem_model(z_mem_addr);

  always @(posedge clock) if (mem_valid === 1'b1) mem_cnt <= mem_cnt + 1;

  sim_mem_arbiter #(.XLEN(32), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_data(lsu_resp_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  sim_mem_arbiter #(.XLEN(32), .LATENCY(0)) dut_lat0 (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(z_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(z_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data(z_ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(z_lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(z_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_data(z_lsu_resp_data),
    .mem_valid(z_mem_valid), .mem_addr(z_mem_addr), .mem_wen(z_mem_wen),
    .mem_wdata(z_mem_wdata), .mem_wmask(z_mem_wmask), .mem_rdata(z_mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 1'b0;
    tick(); tick();
    // Reset held with both requesters asserting valid.
    check_eq("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    check_eq("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    check_eq("rst_resp_data", ifu_resp_data | lsu_resp_data, 32'd0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; reset = 1'b0;
    tick();

    // IFU-only read, LATENCY=2.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; #1;
    check_eq("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
    check_eq("t1_lsu_ready", 32'(lsu_req_ready), 32'd0);
    tick(); ifu_req_valid = 1'b0; #1;
    check_eq("t1_busy_ready", 32'(ifu_req_ready), 32'd0);
    tick();
    check_eq("t1_mem_early", 32'(mem_valid), 32'd0);
    tick();
    check_eq("t1_mem_valid", 32'(mem_valid), 32'd1);
    check_eq("t1_mem_addr", mem_addr, 32'h8000_0000);
    check_eq("t1_mem_wen", 32'(mem_wen), 32'd0);
    check_eq("t1_mem_wmask", 32'(mem_wmask), 32'hF);
    tick();
    check_eq("t1_mem_once", 32'(mem_valid), 32'd0);
    check_eq("t1_resp_valid", 32'(ifu_resp_valid), 32'd1);
    check_eq("t1_resp_data", ifu_resp_data, 32'h0000_0413);
    check_eq("t1_lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    ifu_resp_ready = 1'b1;
    tick(); ifu_resp_ready = 1'b0;
    check_eq("t1_done", 32'(ifu_resp_valid), 32'd0);

    // LSU partial write with unaligned address.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1003; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011; #1;
    check_eq("t2_lsu_ready", 32'(lsu_req_ready), 32'd1);
    tick(); lsu_req_valid = 1'b0;
    tick(); tick();
    check_eq("t2_mem_valid", 32'(mem_valid), 32'd1);
    check_eq("t2_mem_addr", mem_addr, 32'h8000_1000);
    check_eq("t2_mem_wen", 32'(mem_wen), 32'd1);
    check_eq("t2_mem_wmask", 32'(mem_wmask), 32'h3);
    check_eq("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check_eq("t2_resp_valid", 32'(lsu_resp_valid), 32'd1);
    check_eq("t2_resp_data", lsu_resp_data, 32'h0);
    check_eq("t2_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    lsu_resp_ready = 1'b1;
    tick();

    // Simultaneous requests; reset first so any last-grant state starts at IFU.
    reset = 1'b1; tick(); reset = 1'b0;
    lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0100;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_resp_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t3_lsu_grant%0d", k), 32'(lsu_req_ready), 32'(ExpLsuGrant[k]));
      check_eq($sformatf("t3_ifu_grant%0d", k), 32'(ifu_req_ready), 32'(!ExpLsuGrant[k]));
      tick();
      if (k == 2) begin
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      end
      repeat (4) tick();
    end

    // Backpressure on IFU response while LSU waits.
    ifu_resp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010; #1;
    check_eq("t4_ifu_ready", 32'(ifu_req_ready), 32'd1);
    m0 = mem_cnt;
    tick(); ifu_req_valid = 1'b0;
    repeat (3) tick();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t4_hold_valid%0d", k), 32'(ifu_resp_valid), 32'd1);
      check_eq($sformatf("t4_hold_data%0d", k), ifu_resp_data, 32'h25A5_A5B5);
      check_eq($sformatf("t4_lsu_blocked%0d", k), 32'(lsu_req_ready), 32'd0);
      tick();
    end
    ifu_resp_ready = 1'b1; #1;
    check_eq("t4_hs_lsu_blocked", 32'(lsu_req_ready), 32'd0);
    tick(); ifu_resp_ready = 1'b0; #1;
    check_eq("t4_lsu_granted", 32'(lsu_req_ready), 32'd1);
    check_eq("t4_mem_pulses", 32'(mem_cnt - m0), 32'd1);
    tick(); lsu_req_valid = 1'b0;
    repeat (3) tick();
    check_eq("t4_lsu_resp_valid", 32'(lsu_resp_valid), 32'd1);
    check_eq("t4_lsu_resp_data", lsu_resp_data, 32'h25A5_85A5);
    tick();

    // Reset pulsed while in WAIT.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; #1;
    tick(); ifu_req_valid = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; #1;
    check_eq("t5_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("t5_readies", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
    check_eq("t5_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    check_eq("t5_resp_data", ifu_resp_data | lsu_resp_data, 32'd0);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020; #1;
    check_eq("t5_new_ready", 32'(ifu_req_ready), 32'd1);
    tick(); ifu_req_valid = 1'b0;
    check_eq("t5_no_stale_mem1", 32'(mem_valid), 32'd0);
    tick();
    check_eq("t5_no_stale_mem2", 32'(mem_valid), 32'd0);
    tick();
    check_eq("t5_mem_valid_new", 32'(mem_valid), 32'd1);
    check_eq("t5_mem_addr_new", mem_addr, 32'h8000_0020);
    tick();
    check_eq("t5_resp_data_new", ifu_resp_data, 32'h25A5_A585);
    ifu_resp_ready = 1'b1;
    tick(); ifu_resp_ready = 1'b0;

    // LATENCY=0 instance.
    reset = 1'b1; tick(); reset = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; #1;
    check_eq("t6_ready", 32'(z_ifu_req_ready), 32'd1);
    tick(); ifu_req_valid = 1'b0;
    check_eq("t6_mem_valid", 32'(z_mem_valid), 32'd1);
    check_eq("t6_mem_addr", z_mem_addr, 32'h8000_0000);
    check_eq("t6_resp_early", 32'(z_ifu_resp_valid), 32'd0);
    check_eq("t6_lat2_not_yet", 32'(mem_valid), 32'd0);
    tick();
    check_eq("t6_resp_valid", 32'(z_ifu_resp_valid), 32'd1);
    check_eq("t6_resp_data", z_ifu_resp_data, 32'h0000_0413);
    ifu_resp_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
